// File: rtl/usb_packet_tx.sv
// ---------------------------------------------------------------------------
// usb_packet_tx
//
// Transmit side of the FT245-style USB FIFO link. On a Start request it frames
// one response packet for the host: a run of header symbols, Length payload
// bytes fetched from local RAM, then a run of trailer symbols. Each byte is
// pushed into the FT chip with the TXE#/WR handshake: wait for room (TXE# low),
// drive the bus, pulse WR high, drop WR (the FT latches on that falling edge),
// then release the bus and give TXE# time to update before the next byte.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   Start        one-cycle request to send a packet (ignored while Busy)
//   Length       payload byte count, sampled with Start (0 allowed)
//   Busy         packet in progress
//   Done         one-cycle pulse at end of packet (normal or aborted)
//   Error        sticky TXE# timeout flag, cleared by the next accepted Start
//   RAM_Addr     payload read address
//   RAM_RE       payload read strobe; RAM_Data is valid the following cycle
//   RAM_Data     payload byte from RAM
//   FT_TXEn      FT TX FIFO full flag, active low, asynchronous to clk
//   FT_WR        write strobe to the FT
//   FT_OE        enable for the FT data bus output buffer
//   FT_DATA_Out  byte driven to the FT
// ---------------------------------------------------------------------------
module usb_packet_tx #(
  parameter logic [7:0] HEADER_KEY_SYMBOL         = 8'h55,
  parameter int         HEADER_KEY_SYMBOL_NUMBER  = 12,
  parameter logic [7:0] TRAILER_KEY_SYMBOL        = 8'hAA,
  parameter int         TRAILER_KEY_SYMBOL_NUMBER = 8,
  parameter int         ADDR_W                    = 8,
  parameter int         WR_PULSE                  = 3,
  parameter int         RECOVERY                  = 4,
  parameter int         TIMEOUT                   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Length,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic              RAM_RE,
  input  logic [7:0]        RAM_Data,
  input  logic              FT_TXEn,
  output logic              FT_WR,
  output logic              FT_OE,
  output logic [7:0]        FT_DATA_Out
);

  // The byte counter must hold both symbol counts (up to 255) and Length.
  localparam int CNT_W   = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int TMR_MAX = (WR_PULSE > RECOVERY) ? WR_PULSE : RECOVERY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  HDR_CNT    = CNT_W'(HEADER_KEY_SYMBOL_NUMBER);
  localparam logic [CNT_W-1:0]  TRL_LAST   = CNT_W'(TRAILER_KEY_SYMBOL_NUMBER - 1);
  localparam logic [TMR_W-1:0]  STROBE_END = TMR_W'(WR_PULSE - 1);
  localparam logic [TMR_W-1:0]  RECOV_END  = TMR_W'(RECOVERY - 1);
  localparam logic [WAIT_W-1:0] WAIT_END   = WAIT_W'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_NEXT    = 4'd1;
  localparam logic [3:0] S_FETCH   = 4'd2;
  localparam logic [3:0] S_CAPTURE = 4'd3;
  localparam logic [3:0] S_WAITTXE = 4'd4;
  localparam logic [3:0] S_SETUP   = 4'd5;
  localparam logic [3:0] S_STROBE  = 4'd6;
  localparam logic [3:0] S_HOLD    = 4'd7;
  localparam logic [3:0] S_RECOVER = 4'd8;

  localparam logic [1:0] PH_HEADER  = 2'd0;
  localparam logic [1:0] PH_PAYLOAD = 2'd1;
  localparam logic [1:0] PH_TRAILER = 2'd2;

  logic [3:0]        state_q,   state_d;
  logic [1:0]        phase_q,   phase_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [ADDR_W-1:0] len_q,     len_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [7:0]        byte_q,    byte_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [TMR_W-1:0]  tmr_q,     tmr_d;
  logic              done_q,    done_d;
  logic              error_q,   error_d;
  logic              ramRe_q,   ramRe_d;
  logic              ftWr_q,    ftWr_d;
  logic              ftOe_q,    ftOe_d;
  logic [7:0]        ftData_q,  ftData_d;
  logic              txeMeta_q, txeSync_q;
  logic [CNT_W-1:0]  lenExt;

  assign lenExt = CNT_W'(len_q);

  // Two-flop synchronizer for the asynchronous FIFO-full flag. It resets to
  // "full" so nothing is written before the real flag has been observed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txeMeta_q <= 1'b1;
      txeSync_q <= 1'b1;
    end else begin
      txeMeta_q <= FT_TXEn;
      txeSync_q <= txeMeta_q;
    end
  end

  // Packet sequencer. NEXT decides which phase supplies the next byte and
  // performs phase changes in the same cycle, so an empty payload phase costs
  // no extra cycles. The byte counter is advanced at the end of RECOVER.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    waitCnt_d = waitCnt_q;
    tmr_d     = tmr_q;
    done_d    = 1'b0;
    error_d   = error_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          len_d     = Length;
          error_d   = 1'b0;
          addr_d    = '0;
          phase_d   = PH_HEADER;
          cnt_d     = '0;
          waitCnt_d = '0;
          state_d   = S_NEXT;
        end
      end

      S_NEXT: begin
        case (phase_q)
          PH_HEADER: begin
            if (cnt_q != HDR_CNT) begin
              byte_d  = HEADER_KEY_SYMBOL;
              state_d = S_WAITTXE;
            end else if (lenExt != '0) begin
              phase_d = PH_PAYLOAD;
              cnt_d   = '0;
              state_d = S_FETCH;
            end else begin
              phase_d = PH_TRAILER;
              cnt_d   = '0;
              byte_d  = TRAILER_KEY_SYMBOL;
              state_d = S_WAITTXE;
            end
          end
          PH_PAYLOAD: begin
            if (cnt_q != lenExt) begin
              state_d = S_FETCH;
            end else begin
              phase_d = PH_TRAILER;
              cnt_d   = '0;
              byte_d  = TRAILER_KEY_SYMBOL;
              state_d = S_WAITTXE;
            end
          end
          default: begin
            byte_d  = TRAILER_KEY_SYMBOL;
            state_d = S_WAITTXE;
          end
        endcase
      end

      S_FETCH: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        byte_d  = RAM_Data;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_WAITTXE;
      end

      // The wait counter is per byte; a host that stops draining the FIFO
      // aborts the packet instead of hanging the link.
      S_WAITTXE: begin
        if (!txeSync_q) begin
          state_d = S_SETUP;
        end else if (waitCnt_q == WAIT_END) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end

      S_SETUP: begin
        tmr_d   = '0;
        state_d = S_STROBE;
      end

      S_STROBE: begin
        if (tmr_q == STROBE_END) begin
          state_d = S_HOLD;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_HOLD: begin
        tmr_d   = '0;
        state_d = S_RECOVER;
      end

      // RECOVER spans the synchronizer latency, so the TXE# value seen in the
      // next WAIT already reflects the byte just written.
      S_RECOVER: begin
        waitCnt_d = '0;
        if (tmr_q == RECOV_END) begin
          if (phase_q == PH_TRAILER && cnt_q == TRL_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_NEXT;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus-side outputs are decoded from the next state and registered so the
  // strobe and enable leaving the chip are glitch-free flop outputs.
  always_comb begin
    ramRe_d  = (state_d == S_FETCH);
    ftWr_d   = (state_d == S_STROBE);
    ftOe_d   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    ftData_d = ftOe_d ? byte_d : 8'h00;
  end

  // State and output registers; an asynchronous reset drops the bus at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_HEADER;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      byte_q    <= '0;
      waitCnt_q <= '0;
      tmr_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ramRe_q   <= 1'b0;
      ftWr_q    <= 1'b0;
      ftOe_q    <= 1'b0;
      ftData_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      waitCnt_q <= waitCnt_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ramRe_q   <= ramRe_d;
      ftWr_q    <= ftWr_d;
      ftOe_q    <= ftOe_d;
      ftData_q  <= ftData_d;
    end
  end

  assign Busy        = (state_q != S_IDLE);
  assign Done        = done_q;
  assign Error       = error_q;
  assign RAM_Addr    = addr_q;
  assign RAM_RE      = ramRe_q;
  assign FT_WR       = ftWr_q;
  assign FT_OE       = ftOe_q;
  assign FT_DATA_Out = ftData_q;

endmodule

// File: doc/usb_packet_tx.md
Name: usb_packet_tx

Overview:
- Transmit side of the FT245-style USB FIFO link; the counterpart of the packet receiver that decodes host-to-FPGA frames.
- On Start, frames a response packet for the host: 12 header bytes (0x55), Length payload bytes read from local RAM, then 8 trailer bytes (0xAA).
- Writes each byte into the FT chip using the TXE#/WR handshake, with configurable strobe timing and a TXE# timeout.

Parameters:
HEADER_KEY_SYMBOL, 8'h55, header byte value
HEADER_KEY_SYMBOL_NUMBER, 12, header byte count (1..255)
TRAILER_KEY_SYMBOL, 8'hAA, trailer byte value
TRAILER_KEY_SYMBOL_NUMBER, 8, trailer byte count (1..255)
ADDR_W, 8, RAM address width
WR_PULSE, 3, FT_WR high time, cycles (>=1)
RECOVERY, 4, cycles after WR falling edge before TXE# is re-sampled (>=3, covers 2-FF sync)
TIMEOUT, 1000, max cycles waiting for TXE# low before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle request to send a packet
Length  in  ADDR_W  payload byte count, sampled with Start (0 allowed)
Busy  out  1  packet in progress
Done  out  1  one-cycle pulse at end of packet (normal or aborted)
Error  out  1  sticky TXE# timeout flag
RAM_Addr  out  ADDR_W  payload read address
RAM_RE  out  1  payload read strobe; RAM_Data valid the following cycle
RAM_Data  in  8  payload byte from RAM
FT_TXEn  in  1  FT TX FIFO full flag, active low, asynchronous to clk
FT_WR  out  1  write strobe; the FT latches data on the falling edge
FT_OE  out  1  enable for the FT data bus output buffer
FT_DATA_Out  out  8  byte driven to the FT

Behaviour:
- Reset (async): all outputs 0, Error cleared, FSM returns to IDLE. Reset asserted mid-packet drops FT_WR and FT_OE immediately and does not resume after release.
- FT_TXEn passes through a 2-FF synchronizer, reset value 1 (busy). All FSM decisions use the synchronized value.
- IDLE: Busy=0. When Start=1, latch Length, clear Error, set RAM_Addr=0, phase=HEADER, byte counter=0, go to NEXT. Start is ignored while Busy=1.
- NEXT: chooses the source of the next byte.
  - Header: load the header symbol and go to WAIT_TXE.
  - Payload: go to FETCH.
  - Trailer: load the trailer symbol and go to WAIT_TXE.
  - Phase advances when the counter reaches the phase count. A payload phase with Length=0 is skipped and RAM_RE never fires.
- FETCH: RAM_RE=1 for one cycle, then CAPTURE.
- CAPTURE: register RAM_Data, increment RAM_Addr (wraps mod 2^ADDR_W), go to WAIT_TXE.
- WAIT_TXE: leave when synchronized TXE#=0 and go to SETUP. Each cycle spent here increments the wait counter. If it reaches TIMEOUT, set Error=1, pulse Done, go to IDLE; FT_WR stays 0.
- SETUP (1 cycle): FT_OE=1, FT_DATA_Out=byte.
- STROBE (WR_PULSE cycles): FT_WR=1, data held.
- HOLD (1 cycle): FT_WR=0, data and FT_OE held. This is the falling-edge latch point.
- RECOVER (RECOVERY cycles): FT_OE=0, FT_DATA_Out=0, wait counter cleared, counter++, then NEXT.
- After the last trailer byte's RECOVER: pulse Done for one cycle, Busy=0, return to IDLE.
- Busy=1 from the cycle after Start is accepted until Done.
- Cycle count with FT_TXEn held low and default parameters:
  - NEXT+WAIT+SETUP+STROBE+HOLD+RECOVER = 1+1+1+3+1+4 = 11 cycles per byte.
  - Each payload byte adds 2 (FETCH, CAPTURE).
  - Done is asserted on cycle 1 + 11*(20+Length) + 2*Length after the Start edge.
- FT_WR is never 1 unless FT_OE=1. FT_WR never rises twice without an intervening RECOVER.

Test Plan:
- Length=4, RAM[0..3]=12,34,56,78, FT_TXEn=0 constant -> FT_WR falling edges carry 12x55, 12,34,56,78, 8xAA (24 bytes); RAM_RE fires exactly 4 times at addr 0..3; Done on cycle 273.
- Length=0 -> 20 bytes (12x55, 8xAA), no RAM_RE, Done on cycle 221.
- FT_TXEn driven high by a model for 50 cycles after every WR falling edge -> no FT_WR while synchronized TXE#=1; byte order and content unchanged.
- FT_TXEn stuck at 1 after byte 5 -> after 1000 wait cycles Error=1, Done pulses once, FT_WR=0; next Start clears Error and sends a full packet.
- Start pulsed again while Busy, Length=9 -> ignored; the packet length stays as first latched. Length=255 with ADDR_W=8 -> addresses 0..254, no wrap.
- Reset asserted during STROBE of payload byte 2 -> FT_WR, FT_OE, Busy drop asynchronously; after release the block is in IDLE, Done=0, and a new Start sends a full packet.
